// File: rtl/m_sequencer.sv
// Control FSM for the RV32M multiply/divide unit: sequences the m_registers
// datapath selects and reports completion, result register and negation.
module m_sequencer #(
    parameter int MULT_LATENCY = 1,
    localparam int MUX_A_LENGTH = 2,
    localparam int MUX_B_LENGTH = 2,
    localparam int MUX_R_LENGTH = 3,
    localparam int MUX_D_LENGTH = 2,
    localparam int MUX_Z_LENGTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              funct3,
    input  logic                    rs1_sign,
    input  logic                    rs2_sign,
    input  logic                    rs2_zero,
    input  logic                    flush,
    output logic [MUX_A_LENGTH-1:0] mux_A,
    output logic [MUX_B_LENGTH-1:0] mux_B,
    output logic [MUX_R_LENGTH-1:0] mux_R,
    output logic [MUX_D_LENGTH-1:0] mux_D,
    output logic [MUX_Z_LENGTH-1:0] mux_Z,
    output logic                    ready,
    output logic                    done,
    output logic                    result_sel_z,
    output logic                    result_neg
);

    localparam logic [MUX_A_LENGTH-1:0] A_ZERO       = 2'd0;
    localparam logic [MUX_A_LENGTH-1:0] A_R_UNSIGNED = 2'd1;
    localparam logic [MUX_A_LENGTH-1:0] A_R_SIGNED   = 2'd2;
    localparam logic [MUX_B_LENGTH-1:0] B_ZERO       = 2'd0;
    localparam logic [MUX_B_LENGTH-1:0] B_D_UNSIGNED = 2'd1;
    localparam logic [MUX_B_LENGTH-1:0] B_D_SIGNED   = 2'd2;
    localparam logic [MUX_R_LENGTH-1:0] R_KEEP       = 3'd0;
    localparam logic [MUX_R_LENGTH-1:0] R_A          = 3'd1;
    localparam logic [MUX_R_LENGTH-1:0] R_A_NEG      = 3'd2;
    localparam logic [MUX_R_LENGTH-1:0] R_SUB_KEEP   = 3'd3;
    localparam logic [MUX_R_LENGTH-1:0] R_MULT_LOWER = 3'd4;
    localparam logic [MUX_D_LENGTH-1:0] D_KEEP       = 2'd0;
    localparam logic [MUX_D_LENGTH-1:0] D_B          = 2'd1;
    localparam logic [MUX_D_LENGTH-1:0] D_B_NEG      = 2'd2;
    localparam logic [MUX_D_LENGTH-1:0] D_SHR        = 2'd3;
    localparam logic [MUX_Z_LENGTH-1:0] Z_KEEP       = 2'd0;
    localparam logic [MUX_Z_LENGTH-1:0] Z_ZERO       = 2'd1;
    localparam logic [MUX_Z_LENGTH-1:0] Z_SHL_ADD    = 2'd2;
    localparam logic [MUX_Z_LENGTH-1:0] Z_MULT_UPPER = 2'd3;

    localparam logic [4:0] LAST_WAIT = 5'(MULT_LATENCY - 1);
    localparam logic [4:0] LAST_ITER = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_MUL_WB,
        S_DIV_ITER,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [4:0]              cnt_q;
    logic [2:0]              op_q;
    logic                    q_neg_q;
    logic                    r_neg_q;
    logic                    done_q;
    logic                    sel_z_q;
    logic                    neg_q;
    logic                    ready_q;
    logic [MUX_A_LENGTH-1:0] mux_a_q;
    logic [MUX_B_LENGTH-1:0] mux_b_q;
    logic [MUX_R_LENGTH-1:0] mux_r_q;
    logic [MUX_D_LENGTH-1:0] mux_d_q;
    logic [MUX_Z_LENGTH-1:0] mux_z_q;

    logic accept_s;
    logic div_signed_s;

    assign accept_s     = start && ready_q && !flush && !reset;
    assign div_signed_s = funct3[2] && !funct3[0];

    function automatic logic [MUX_A_LENGTH-1:0] mul_a_sel(input logic [2:0] f);
        return ((f == 3'b001) || (f == 3'b010)) ? A_R_SIGNED : A_R_UNSIGNED;
    endfunction

    function automatic logic [MUX_B_LENGTH-1:0] mul_b_sel(input logic [2:0] f);
        return (f == 3'b001) ? B_D_SIGNED : B_D_UNSIGNED;
    endfunction

    // High-word multiplies and quotients come back from Z; MUL and remainders from R.
    function automatic logic sel_z_of(input logic [2:0] f);
        return (f != 3'b000) && (f != 3'b110) && (f != 3'b111);
    endfunction

    function automatic logic neg_of(input logic [2:0] f, input logic qn, input logic rn);
        return (f == 3'b100) ? qn : ((f == 3'b110) ? rn : 1'b0);
    endfunction

    // Sequencer state, counters, latched operation and registered select values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            sel_z_q <= 1'b0;
            neg_q   <= 1'b0;
            ready_q <= 1'b1;
            mux_a_q <= A_ZERO;
            mux_b_q <= B_ZERO;
            mux_r_q <= R_KEEP;
            mux_d_q <= D_KEEP;
            mux_z_q <= Z_KEEP;
            if (reset) begin
                op_q    <= 3'd0;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        ready_q <= 1'b0;
                        cnt_q   <= 5'd0;
                        if (funct3[2]) begin
                            q_neg_q <= div_signed_s && (rs1_sign ^ rs2_sign) && !rs2_zero;
                            r_neg_q <= div_signed_s && rs1_sign;
                            state_q <= S_DIV_ITER;
                            mux_a_q <= A_R_UNSIGNED;
                            mux_b_q <= B_D_UNSIGNED;
                            mux_r_q <= R_SUB_KEEP;
                            mux_d_q <= D_SHR;
                            mux_z_q <= Z_SHL_ADD;
                        end else begin
                            state_q <= S_MUL_ISSUE;
                            mux_a_q <= mul_a_sel(funct3);
                            mux_b_q <= mul_b_sel(funct3);
                        end
                    end
                end
                S_MUL_ISSUE: begin
                    state_q <= S_MUL_WAIT;
                    cnt_q   <= 5'd0;
                end
                S_MUL_WAIT: begin
                    if (cnt_q == LAST_WAIT) begin
                        cnt_q   <= 5'd0;
                        state_q <= S_MUL_WB;
                        mux_r_q <= R_MULT_LOWER;
                        mux_z_q <= Z_MULT_UPPER;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_MUL_WB: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    sel_z_q <= sel_z_of(op_q);
                    neg_q   <= neg_of(op_q, q_neg_q, r_neg_q);
                    mux_a_q <= A_ZERO;
                    mux_b_q <= B_ZERO;
                    mux_r_q <= R_KEEP;
                    mux_z_q <= Z_KEEP;
                end
                S_DIV_ITER: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        sel_z_q <= sel_z_of(op_q);
                        neg_q   <= neg_of(op_q, q_neg_q, r_neg_q);
                        mux_a_q <= A_ZERO;
                        mux_b_q <= B_ZERO;
                        mux_r_q <= R_KEEP;
                        mux_d_q <= D_KEEP;
                        mux_z_q <= Z_KEEP;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    sel_z_q <= 1'b0;
                    neg_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 5'd0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    mux_a_q <= A_ZERO;
                    mux_b_q <= B_ZERO;
                    mux_r_q <= R_KEEP;
                    mux_d_q <= D_KEEP;
                    mux_z_q <= Z_KEEP;
                end
            endcase
        end
    end

    // Accept-cycle operand load is driven straight from the request; flush/reset force idle selects.
    always_comb begin
        if (reset || flush) begin
            mux_A = A_ZERO;
            mux_B = B_ZERO;
            mux_R = R_KEEP;
            mux_D = D_KEEP;
            mux_Z = Z_KEEP;
        end else if (accept_s) begin
            mux_A = A_ZERO;
            mux_B = B_ZERO;
            if (funct3[2]) begin
                mux_R = (div_signed_s && rs1_sign) ? R_A_NEG : R_A;
                mux_D = (div_signed_s && rs2_sign) ? D_B_NEG : D_B;
                mux_Z = Z_ZERO;
            end else begin
                mux_R = R_A;
                mux_D = D_B;
                mux_Z = Z_KEEP;
            end
        end else begin
            mux_A = mux_a_q;
            mux_B = mux_b_q;
            mux_R = mux_r_q;
            mux_D = mux_d_q;
            mux_Z = mux_z_q;
        end
    end

    assign ready        = ready_q;
    assign done         = done_q && !flush && !reset;
    assign result_sel_z = sel_z_q;
    assign result_neg   = neg_q;

endmodule

// File: tb/tb_m_sequencer.sv
// Directed self-checking bench for m_sequencer; a second instance with
// MULT_LATENCY=3 runs in lockstep to check the latency parameter.
module tb_m_sequencer;

    localparam logic [1:0] A_ZERO = 2'd0, A_RU = 2'd1, A_RS = 2'd2;
    localparam logic [1:0] B_ZERO = 2'd0, B_DU = 2'd1, B_DS = 2'd2;
    localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_ANEG = 3'd2, R_SUB = 3'd3, R_MLO = 3'd4;
    localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_BNEG = 2'd2, D_SHR = 2'd3;
    localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL = 2'd2, Z_MUP = 2'd3;

    logic       clk = 1'b0;
    logic       reset, start, flush, rs1_sign, rs2_sign, rs2_zero;
    logic [2:0] funct3;
    logic [1:0] mux_A, mux_B, mux_D, mux_Z, mux_A3, mux_B3, mux_D3, mux_Z3;
    logic [2:0] mux_R, mux_R3;
    logic       ready, done, result_sel_z, result_neg;
    logic       ready3, done3, result_sel_z3, result_neg3;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    m_sequencer #(.MULT_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero), .flush(flush),
        .mux_A(mux_A), .mux_B(mux_B), .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
        .ready(ready), .done(done), .result_sel_z(result_sel_z), .result_neg(result_neg)
    );

    m_sequencer #(.MULT_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero), .flush(flush),
        .mux_A(mux_A3), .mux_B(mux_B3), .mux_R(mux_R3), .mux_D(mux_D3), .mux_Z(mux_Z3),
        .ready(ready3), .done(done3), .result_sel_z(result_sel_z3), .result_neg(result_neg3)
    );

    function automatic logic [10:0] pk(input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] r, input logic [1:0] d,
                                       input logic [1:0] z);
        return {a, b, r, d, z};
    endfunction

    function automatic logic [10:0] muxes();
        return pk(mux_A, mux_B, mux_R, mux_D, mux_Z);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] f, input logic s1, input logic s2, input logic z);
        funct3   = f;
        rs1_sign = s1;
        rs2_sign = s2;
        rs2_zero = z;
        start    = 1'b1;
        #1;
    endtask

    // Walks forward from cycle index 'base' (relative to accept) until both instances pulse done.
    task automatic wait_done(input int base, output int lat1, output int lat3,
                             output logic sz, output logic ng, output int pulses);
        lat1 = -1; lat3 = -1; sz = 1'b0; ng = 1'b0; pulses = 0;
        for (int k = base; k < base + 60; k++) begin
            if (done) begin
                pulses++;
                if (lat1 < 0) begin
                    lat1 = k; sz = result_sel_z; ng = result_neg;
                end
            end
            if (done3 && lat3 < 0) lat3 = k;
            if (lat1 >= 0 && lat3 >= 0) break;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic s1,
                          input logic s2, input logic z, input logic [10:0] acc_sel,
                          input logic [10:0] run_sel, input int exp_l1, input int exp_l3,
                          input logic exp_sz, input logic exp_ng);
        int l1, l3, np;
        logic sz, ng;
        accept(f, s1, s2, z);
        check({tag, "_accept_sel"}, muxes(), acc_sel);
        tick();
        start = 1'b0;
        #1;
        check({tag, "_run_sel"}, muxes(), run_sel);
        wait_done(1, l1, l3, sz, ng, np);
        check({tag, "_lat"}, l1, exp_l1);
        check({tag, "_lat3"}, l3, exp_l3);
        check({tag, "_sel_z"}, sz, exp_sz);
        check({tag, "_neg"}, ng, exp_ng);
        check({tag, "_pulses"}, np, 1);
        tick();
        check({tag, "_ready_after"}, {ready, ready3, done}, 3'b110);
    endtask

    initial begin
        int l1, l3, np, bad;
        logic sz, ng;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
        rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_flags", {ready, done, result_sel_z, result_neg, ready3}, 5'b10001);
        check("reset_muxes", muxes(), pk(A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP));

        // MULHU walked cycle by cycle.
        accept(3'b011, 1'b1, 1'b1, 1'b0);
        check("mulhu_accept_sel", muxes(), pk(A_ZERO, B_ZERO, R_A, D_B, Z_KEEP));
        tick();
        start = 1'b0;
        #1;
        check("mulhu_t1_sel", muxes(), pk(A_RU, B_DU, R_KEEP, D_KEEP, Z_KEEP));
        check("mulhu_t1_ready", ready, 1'b0);
        tick();
        check("mulhu_t2_sel", muxes(), pk(A_RU, B_DU, R_KEEP, D_KEEP, Z_KEEP));
        tick();
        check("mulhu_t3_wb_sel", muxes(), pk(A_RU, B_DU, R_MLO, D_KEEP, Z_MUP));
        wait_done(3, l1, l3, sz, ng, np);
        check("mulhu_lat", l1, 4);
        check("mulhu_lat3", l3, 6);
        check("mulhu_flags", {sz, ng}, 2'b10);
        check("mulhu_pulses", np, 1);
        tick();
        check("mulhu_ready_after", {ready, ready3, done}, 3'b110);

        run_op("mulh", 3'b001, 1'b1, 1'b0, 1'b0, pk(A_ZERO, B_ZERO, R_A, D_B, Z_KEEP),
               pk(A_RS, B_DS, R_KEEP, D_KEEP, Z_KEEP), 4, 6, 1'b1, 1'b0);
        run_op("mulhsu", 3'b010, 1'b1, 1'b1, 1'b0, pk(A_ZERO, B_ZERO, R_A, D_B, Z_KEEP),
               pk(A_RS, B_DU, R_KEEP, D_KEEP, Z_KEEP), 4, 6, 1'b1, 1'b0);
        run_op("mul", 3'b000, 1'b1, 1'b1, 1'b0, pk(A_ZERO, B_ZERO, R_A, D_B, Z_KEEP),
               pk(A_RU, B_DU, R_KEEP, D_KEEP, Z_KEEP), 4, 6, 1'b0, 1'b0);

        // Divide family: accept-cycle sign handling and final negate flags.
        run_op("div_m7_2", 3'b100, 1'b1, 1'b0, 1'b0, pk(A_ZERO, B_ZERO, R_ANEG, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b1, 1'b1);
        run_op("rem_m7_2", 3'b110, 1'b1, 1'b0, 1'b0, pk(A_ZERO, B_ZERO, R_ANEG, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b0, 1'b1);
        run_op("divu_5_0", 3'b101, 1'b0, 1'b0, 1'b1, pk(A_ZERO, B_ZERO, R_A, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b1, 1'b0);
        run_op("rem_m5_0", 3'b110, 1'b1, 1'b0, 1'b1, pk(A_ZERO, B_ZERO, R_ANEG, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b0, 1'b1);
        run_op("div_m5_0", 3'b100, 1'b1, 1'b0, 1'b1, pk(A_ZERO, B_ZERO, R_ANEG, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b1, 1'b0);
        run_op("div_ovf", 3'b100, 1'b1, 1'b1, 1'b0, pk(A_ZERO, B_ZERO, R_ANEG, D_BNEG, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b1, 1'b0);
        run_op("remu_neg", 3'b111, 1'b1, 1'b1, 1'b0, pk(A_ZERO, B_ZERO, R_A, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b0, 1'b0);

        // start held high throughout a DIVU; the MUL behind it goes in right after done.
        accept(3'b101, 1'b0, 1'b0, 1'b0);
        tick();
        funct3 = 3'b000;
        #1;
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (ready || done || mux_R != R_SUB) bad++;
            tick();
        end
        check("held_start_ignored", bad, 0);
        check("held_done_t33", {done, ready}, 2'b10);
        tick();
        check("held_accept_t34", {ready, muxes()}, {1'b1, pk(A_ZERO, B_ZERO, R_A, D_B, Z_KEEP)});
        tick();
        start = 1'b0;
        #1;
        check("held_mul_issue", {ready, muxes()}, {1'b0, pk(A_RU, B_DU, R_KEEP, D_KEEP, Z_KEEP)});
        wait_done(1, l1, l3, sz, ng, np);
        check("held_mul_lat", {l1[7:0], l3[7:0]}, {8'd4, 8'd6});
        tick();

        // Flush at DIV_ITER cnt=10, then flush racing a start in IDLE.
        accept(3'b100, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        #1;
        repeat (10) tick();
        flush = 1'b1;
        #1;
        check("flush_cycle_sel", {done, muxes()}, {1'b0, pk(A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP)});
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle", {ready, ready3, muxes()}, {2'b11, pk(A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP)});
        start = 1'b1;
        funct3 = 3'b100;
        flush = 1'b1;
        #1;
        check("flush_beats_start_sel", muxes(), pk(A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP));
        tick();
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_beats_start_ready", {ready, ready3}, 2'b11);
        bad = 0;
        repeat (40) begin
            if (done || done3) bad++;
            tick();
        end
        check("flush_no_done", bad, 0);
        run_op("div_after_flush", 3'b100, 1'b0, 1'b0, 1'b0, pk(A_ZERO, B_ZERO, R_A, D_B, Z_ZERO),
               pk(A_RU, B_DU, R_SUB, D_SHR, Z_SHL), 33, 33, 1'b1, 1'b0);

        // Reset while both instances sit in MUL_WAIT.
        accept(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        #1;
        check("reset_cycle_sel", {done, muxes()}, {1'b0, pk(A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP)});
        tick();
        reset = 1'b0;
        #1;
        check("reset_mid_idle", {ready, ready3, done, muxes()},
              {3'b110, pk(A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP)});
        bad = 0;
        repeat (10) begin
            if (done || done3) bad++;
            tick();
        end
        check("reset_no_done", bad, 0);
        run_op("mulhu_after_reset", 3'b011, 1'b0, 1'b0, 1'b0, pk(A_ZERO, B_ZERO, R_A, D_B, Z_KEEP),
               pk(A_RU, B_DU, R_KEEP, D_KEEP, Z_KEEP), 4, 6, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/m_sequencer.md
Name: m_sequencer

Overview:
- Control FSM for the M-extension multiply/divide unit.
- Accepts one RV32M operation and drives the mux-select inputs (mux_A, mux_B, mux_R, mux_D, mux_Z) of the m_registers datapath.
  - Multiply: operand load → DSP multiply → writeback.
  - Divide: operand load → 32 restoring iterations.
- Reports completion, which result register (R or Z) to return, and whether the external result stage must negate it.

Parameters:
- MULT_LATENCY, 1, cycles from A/B registered to a valid product at the datapath's registered ALU input; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request; accepted only when ready=1
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_sign  in  1  rs1[31]; sampled only at accept
- rs2_sign  in  1  rs2[31]; sampled only at accept
- rs2_zero  in  1  rs2==0; sampled only at accept
- flush  in  1  abort the current operation
- mux_A  out  MUX_A_LENGTH  datapath A select (m_definitions.svh encodings)
- mux_B  out  MUX_B_LENGTH  datapath B select
- mux_R  out  MUX_R_LENGTH  remainder register select
- mux_D  out  MUX_D_LENGTH  divisor register select
- mux_Z  out  MUX_Z_LENGTH  quotient register select
- ready  out  1  idle and able to accept
- done  out  1  one-cycle pulse; result is valid in R/Z
- result_sel_z  out  1  1: return Z; 0: return R; valid while done=1
- result_neg  out  1  1: result stage returns the two's complement; valid while done=1

Behaviour:
- States: IDLE, MUL_ISSUE, MUL_WAIT, MUL_WB, DIV_ITER, DONE.
- Registered internals:
  - op (funct3 latched)
  - q_neg, r_neg
  - 5-bit counter cnt
- Reset values and idle outputs:
  - state=IDLE, cnt=0, done=0, result_sel_z=0, result_neg=0, ready=1.
  - Mux defaults: KEEP for R/D/Z, ZERO for A/B.
- Accept: start && ready, in cycle T. Selects in cycle T are Mealy, from the inputs:
  - Multiply: mux_R=A, mux_D=B.
  - Signed divide: mux_R=A_NEG if rs1_sign else A; mux_D=B_NEG if rs2_sign else B; mux_Z=ZERO.
  - Unsigned divide: mux_R=A, mux_D=B, mux_Z=ZERO.
  - Latches op. For divide ops it also latches:
    - q_neg = signed & (rs1_sign^rs2_sign) & ~rs2_zero
    - r_neg = signed & rs1_sign
  - Next state: MUL_ISSUE (funct3[2]=0) or DIV_ITER.
- MUL_ISSUE (1 cycle), MUL_WAIT (MULT_LATENCY cycles, cnt counts up), MUL_WB (1 cycle):
  - mux_A = R_SIGNED for MULH/MULHSU, else R_UNSIGNED.
  - mux_B = D_SIGNED for MULH, else D_UNSIGNED.
  - Both selects are held constant across all three states; the Z upper-word sign handling depends on them during MUL_WB.
  - MUL_WB additionally sets mux_R=MULT_LOWER and mux_Z=MULT_UPPER.
- DIV_ITER, 32 cycles (cnt 0..31):
  - mux_R=SUB_KEEP, mux_Z=SHL_ADD, mux_D=SHR; mux_A/mux_B = R_UNSIGNED/D_UNSIGNED.
  - Leaves for DONE when cnt==31.
- DONE, 1 cycle:
  - done=1; all muxes KEEP/ZERO.
  - result_sel_z = 1 for MULH, MULHSU, MULHU, DIV, DIVU; 0 otherwise.
  - result_neg = q_neg for DIV, r_neg for REM, 0 otherwise.
  - Returns to IDLE.
- Latency (start to done, accept cycle T): multiply done at T+3+MULT_LATENCY; divide done at T+33.
- ready = (state==IDLE). start while ready=0 is ignored with no side effects. Back-to-back operation: the earliest accept is the cycle after done.
- Divide by zero: no special path. With D=0 the iterations give Z=all ones and R=|rs1|. q_neg is forced 0, so DIV x/0 returns 0xFFFFFFFF and REM x/0 returns rs1.
- Overflow (DIV -2^31/-1): quotient 0x80000000, remainder 0, with no negate.
- flush in any non-IDLE state:
  - Next state IDLE, cnt=0, no done pulse.
  - Mux outputs in the flush cycle are the IDLE defaults.
- flush in IDLE with start: flush wins, and the op is not accepted.
- reset mid-operation: same as power-on reset next cycle; no done pulse.
- cnt wraps only by reset/flush/state exit; it never counts in IDLE or DONE.

Test Plan:
- MULHU, 0xFFFFFFFF*0xFFFFFFFF, MULT_LATENCY=1:
  - done at T+4, result_sel_z=1, result_neg=0.
  - Datapath Z=0xFFFFFFFE, R=0x00000001.
  - mux_A/mux_B = R_UNSIGNED/D_UNSIGNED held from T+1 through T+3.
- MULH, -2 * 3:
  - mux_A=R_SIGNED, mux_B=D_SIGNED.
  - Z=0xFFFFFFFF, R=0xFFFFFFFA.
  - done at T+3+MULT_LATENCY; repeat with MULT_LATENCY=3 → done at T+6.
- DIV, -7 / 2:
  - Accept-cycle selects mux_R=A_NEG, mux_D=B.
  - DIV_ITER runs 32 cycles; done at T+33.
  - Z=3, result_sel_z=1, result_neg=1 (final −3).
  - Same with REM: result_sel_z=0, result_neg=1, R=1 (final −1).
- DIVU 5/0 and REM −5/0:
  - DIVU: Z=0xFFFFFFFF, result_neg=0.
  - REM: R=5, result_neg=1 (final −5).
- start held high during an active DIV: ignored; ready=0 until DONE+1; the next op is accepted the cycle after done.
- flush at DIV_ITER cnt=10, then reset asserted during MUL_WAIT:
  - Each time: IDLE next cycle, ready=1, no done pulse, muxes at idle defaults.
